generic_fifo_fwft_env: RTL and testbench
========================================

Name: generic_fifo_fwft_env

Overview:
- Parametrised single-clock FIFO envelope; next generation of the 1r1w-RAM FIFO envelopes.
- Adds:
  - first-word-fall-through read port (rd_data valid while rd_valid, no read latency)
  - per-bit write mask
  - programmable almost-full/almost-empty flags
  - synchronous flush
  - sticky high-watermark counter
- Sits between SoC producers/consumers. Storage is an internal 1r1w synchronous-read array, so depth and width are free parameters.

Parameters:
- PTR_WIDTH, 8, address width; requires 2 <= NUM_OF_ENTRIES <= 2**PTR_WIDTH.
- NUM_OF_ENTRIES, 256, total capacity in words; non-power-of-2 allowed.
- DAT_WIDTH, 37, data width.
- AF_THRESH, NUM_OF_ENTRIES-4, almost_full when entry_used >= AF_THRESH.
- AE_THRESH, 4, almost_empty when entry_used <= AE_THRESH.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush.
- wr_op  in  1  push request.
- wr_data  in  DAT_WIDTH  push data.
- wr_mask  in  DAT_WIDTH  1 = bit written; 0 = storage bit keeps its previous content.
- full  out  1  entry_used == NUM_OF_ENTRIES.
- almost_full  out  1  see AF_THRESH.
- wr_full_err  out  1  one-cycle pulse: push rejected.
- rd_op  in  1  pop/acknowledge of the head word.
- rd_data  out  DAT_WIDTH  head word; valid when rd_valid.
- rd_valid  out  1  head word present (== !empty).
- empty  out  1  entry_used == 0.
- almost_empty  out  1  see AE_THRESH.
- rd_empty_err  out  1  one-cycle pulse: pop rejected.
- entry_used  out  PTR_WIDTH+1  current occupancy.
- max_used  out  PTR_WIDTH+1  highest occupancy since reset/hwm_clr.
- hwm_clr  in  1  synchronous clear of max_used.

Behaviour:
- Reset (async assert, sync release):
  - Pointers and count 0; empty=1, rd_valid=0.
  - full=0, almost_full=(AF_THRESH==0), almost_empty=1.
  - Error pulses 0; max_used=0; rd_data=0.
  - Storage array is not reset.
- All flags and entry_used are registered and reflect the state after the last clock edge.
- Push accepted when wr_op && (!full || rd_op). Data lands at wr_ptr under wr_mask; wr_ptr increments, wrapping NUM_OF_ENTRIES-1 -> 0.
- Pop accepted when rd_op && !empty; rd_ptr increments with the same wrap rule.
- Occupancy rules:
  - Push only: +1.
  - Pop only: -1.
  - Both accepted: unchanged.
  - Push+pop when full: both accepted; count stays NUM_OF_ENTRIES.
  - Push+pop when empty: push accepted, pop rejected with rd_empty_err; count becomes 1.
- Rejections:
  - wr_op && full && !rd_op: write dropped; wr_full_err=1 next cycle for one cycle.
  - rd_op && empty: rd_empty_err=1 next cycle for one cycle; state unchanged.
- FWFT latency:
  - Push into an empty FIFO at edge N: rd_valid=1 and rd_data=pushed word (masked-off bits = prior storage content) from after edge N.
  - After an accepted pop at edge N: rd_data shows the next word from after edge N.
  - Back-to-back pops sustain 1 word/cycle, with no bubbles.
  - Read-during-write to the same address returns the newly written data.
  - rd_data holds its value while rd_valid=0.
- clr (highest priority over wr_op/rd_op in the same cycle):
  - Pointers and count go to 0 at the next edge; empty=1, rd_valid=0.
  - No error pulses generated in that cycle.
  - max_used unaffected; storage not cleared.
- max_used: max_used <= max(max_used, next entry_used) each edge.
  - hwm_clr loads the current next entry_used instead.
  - Saturates naturally at NUM_OF_ENTRIES.
- Assertions:
  - entry_used never exceeds NUM_OF_ENTRIES.
  - full && empty never true together.

Test Plan:
- NUM_OF_ENTRIES=4, DAT_WIDTH=8:
  - Push 0x11,0x22,0x33,0x44 -> full=1, entry_used=4, almost_full per AF_THRESH=0 -> 1.
  - 5th push 0x55 -> wr_full_err one cycle, entry_used stays 4.
- Same state, then 4 consecutive rd_op cycles -> rd_data 0x11,0x22,0x33,0x44 on successive cycles, no bubble. Then empty=1; extra rd_op -> rd_empty_err one cycle.
- Empty FIFO, single push 0xA5 at edge N -> rd_valid=1, rd_data=0xA5 right after edge N. Simultaneous push+pop when full -> count stays 4, order preserved.
- Fill 4 with 0xFF, pop all, push 0x00 with wr_mask=0x0F into wrapped slot 0 -> rd_data=0xF0.
- NUM_OF_ENTRIES=5 (non-power-of-2): 12 pushes/pops interleaved -> pointers wrap 4 -> 0, data order intact, entry_used never >5. clr with 3 entries plus concurrent wr_op -> next cycle entry_used=0, empty=1, no error pulses, max_used=3.
- Reset asserted mid-traffic (asynchronously, between edges) -> all outputs immediately at reset values; after release first push behaves as on empty FIFO.

Source files
------------

// File: rtl/generic_fifo_fwft_env.sv
// Single-clock first-word-fall-through FIFO with bit-masked writes, programmable
// almost-full/almost-empty flags, synchronous flush and a sticky high-watermark.
module generic_fifo_fwft_env #(
    parameter int unsigned PTR_WIDTH      = 8,
    parameter int unsigned NUM_OF_ENTRIES = 256,
    parameter int unsigned DAT_WIDTH      = 37,
    parameter int unsigned AF_THRESH      = NUM_OF_ENTRIES - 4,
    parameter int unsigned AE_THRESH      = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic                 wr_op,
    input  logic [DAT_WIDTH-1:0] wr_data,
    input  logic [DAT_WIDTH-1:0] wr_mask,
    output logic                 full,
    output logic                 almost_full,
    output logic                 wr_full_err,
    input  logic                 rd_op,
    output logic [DAT_WIDTH-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 empty,
    output logic                 almost_empty,
    output logic                 rd_empty_err,
    output logic [PTR_WIDTH:0]   entry_used,
    output logic [PTR_WIDTH:0]   max_used,
    input  logic                 hwm_clr
);

    localparam logic [PTR_WIDTH-1:0] LastIdx    = PTR_WIDTH'(NUM_OF_ENTRIES - 1);
    localparam logic [PTR_WIDTH:0]   NumEntries = (PTR_WIDTH + 1)'(NUM_OF_ENTRIES);

    logic [DAT_WIDTH-1:0] mem_q [NUM_OF_ENTRIES];

    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0]   cnt_q, cnt_d, max_q, max_d;
    logic [DAT_WIDTH-1:0] rd_data_q, rd_data_d, wr_word, head_word;
    logic                 full_q, empty_q, af_q, ae_q, wr_err_q, rd_err_q;
    logic                 wr_err_d, rd_err_d, push, pop;

    always_comb begin
        push     = wr_op && (!full_q || rd_op) && !clr;
        pop      = rd_op && !empty_q && !clr;
        wr_err_d = wr_op && full_q && !rd_op && !clr;
        rd_err_d = rd_op && empty_q && !clr;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end

        wr_word = (wr_data & wr_mask) | (mem_q[wr_ptr_q] & ~wr_mask);

        // Register the word at the next head now so it is visible right after the edge;
        // forward the write when it lands on that slot (push into an empty FIFO).
        head_word = (push && (wr_ptr_q == rd_ptr_d)) ? wr_word : mem_q[rd_ptr_d];
        rd_data_d = (cnt_d != '0) ? head_word : rd_data_q;

        if (hwm_clr)            max_d = cnt_d;
        else if (cnt_d > max_q) max_d = cnt_d;
        else                    max_d = max_q;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            max_q     <= '0;
            rd_data_q <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            af_q      <= (AF_THRESH == 0);
            ae_q      <= 1'b1;
            wr_err_q  <= 1'b0;
            rd_err_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            max_q     <= max_d;
            rd_data_q <= rd_data_d;
            full_q    <= (cnt_d == NumEntries);
            empty_q   <= (cnt_d == '0);
            af_q      <= (32'(cnt_d) >= AF_THRESH);
            ae_q      <= (32'(cnt_d) <= AE_THRESH);
            wr_err_q  <= wr_err_d;
            rd_err_q  <= rd_err_d;
        end
    end

    assign full         = full_q;
    assign almost_full  = af_q;
    assign wr_full_err  = wr_err_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = !empty_q;
    assign empty        = empty_q;
    assign almost_empty = ae_q;
    assign rd_empty_err = rd_err_q;
    assign entry_used   = cnt_q;
    assign max_used     = max_q;

    a_cnt_bound: assert property (@(posedge clk) disable iff (!reset_n)
        32'(cnt_q) <= NUM_OF_ENTRIES);
    a_full_empty: assert property (@(posedge clk) disable iff (!reset_n)
        !(full_q && empty_q));

endmodule

// File: tb/tb_generic_fifo_fwft_env.sv
// Scoreboard bench: instance A (4 x 8) covers full/empty/FWFT/mask/async reset,
// instance B (5 x 8) covers non-power-of-2 wrap, hwm_clr and flush.
module tb_generic_fifo_fwft_env;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Instance A signals
    logic       a_clr = 0, a_wr_op = 0, a_rd_op = 0, a_hwm_clr = 0;
    logic [7:0] a_wr_data = 0, a_wr_mask = 0, a_rd_data;
    logic       a_full, a_almost_full, a_wr_full_err, a_rd_valid, a_empty;
    logic       a_almost_empty, a_rd_empty_err;
    logic [2:0] a_entry_used, a_max_used;

    // Instance B signals
    logic       b_clr = 0, b_wr_op = 0, b_rd_op = 0, b_hwm_clr = 0;
    logic [7:0] b_wr_data = 0, b_wr_mask = 0, b_rd_data;
    logic       b_full, b_almost_full, b_wr_full_err, b_rd_valid, b_empty;
    logic       b_almost_empty, b_rd_empty_err;
    logic [3:0] b_entry_used, b_max_used;

    generic_fifo_fwft_env #(
        .PTR_WIDTH(2), .NUM_OF_ENTRIES(4), .DAT_WIDTH(8)
    ) u_a (
        .clk(clk), .reset_n(reset_n), .clr(a_clr), .wr_op(a_wr_op), .wr_data(a_wr_data),
        .wr_mask(a_wr_mask), .full(a_full), .almost_full(a_almost_full),
        .wr_full_err(a_wr_full_err), .rd_op(a_rd_op), .rd_data(a_rd_data),
        .rd_valid(a_rd_valid), .empty(a_empty), .almost_empty(a_almost_empty),
        .rd_empty_err(a_rd_empty_err), .entry_used(a_entry_used), .max_used(a_max_used),
        .hwm_clr(a_hwm_clr)
    );

    generic_fifo_fwft_env #(
        .PTR_WIDTH(3), .NUM_OF_ENTRIES(5), .DAT_WIDTH(8)
    ) u_b (
        .clk(clk), .reset_n(reset_n), .clr(b_clr), .wr_op(b_wr_op), .wr_data(b_wr_data),
        .wr_mask(b_wr_mask), .full(b_full), .almost_full(b_almost_full),
        .wr_full_err(b_wr_full_err), .rd_op(b_rd_op), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .empty(b_empty), .almost_empty(b_almost_empty),
        .rd_empty_err(b_rd_empty_err), .entry_used(b_entry_used), .max_used(b_max_used),
        .hwm_clr(b_hwm_clr)
    );

    // Reference models
    logic [7:0] a_sb[$];
    logic [7:0] b_sb[$];
    logic [7:0] a_mem[4];
    int a_wp = 0, a_cnt = 0, b_cnt = 0, b_max = 0;

    task automatic a_drive(input logic wr, input logic [7:0] d, input logic [7:0] m,
                           input logic rd, input logic cl);
        bit pu, po;
        logic [7:0] w;
        a_wr_op = wr; a_wr_data = d; a_wr_mask = m; a_rd_op = rd; a_clr = cl;
        pu = !cl && wr && (a_cnt < 4 || rd);
        po = !cl && rd && a_cnt > 0;
        if (cl) begin
            a_cnt = 0; a_wp = 0; a_sb.delete();
        end else begin
            if (pu) begin
                w = (d & m) | (a_mem[a_wp] & ~m);
                a_mem[a_wp] = w;
                a_wp = (a_wp + 1) % 4;
                a_sb.push_back(w);
            end
            a_cnt = a_cnt + int'(pu) - int'(po);
        end
        @(posedge clk);
        #1;
        a_wr_op = 0; a_rd_op = 0; a_clr = 0;
    endtask

    task automatic b_drive(input logic wr, input logic [7:0] d, input logic rd,
                           input logic cl, input logic hw);
        bit pu, po;
        b_wr_op = wr; b_wr_data = d; b_wr_mask = 8'hFF; b_rd_op = rd; b_clr = cl;
        b_hwm_clr = hw;
        pu = !cl && wr && (b_cnt < 5 || rd);
        po = !cl && rd && b_cnt > 0;
        if (cl) begin
            b_cnt = 0; b_sb.delete();
        end else begin
            if (pu) b_sb.push_back(d);
            b_cnt = b_cnt + int'(pu) - int'(po);
        end
        if (hw) b_max = b_cnt;
        else if (b_cnt > b_max) b_max = b_cnt;
        @(posedge clk);
        #1;
        b_wr_op = 0; b_rd_op = 0; b_clr = 0; b_hwm_clr = 0;
    endtask

    task automatic test_reset();
        checks++; if (a_empty !== 1'b1 || a_rd_valid !== 1'b0) begin
            failures++; $display("FAIL reset_empty: empty=%b rd_valid=%b, need 1/0", a_empty, a_rd_valid); end
        checks++; if (a_full !== 1'b0 || a_almost_full !== 1'b1 || a_almost_empty !== 1'b1) begin
            failures++; $display("FAIL reset_flags_a: full=%b af=%b ae=%b, need 0/1/1",
                                 a_full, a_almost_full, a_almost_empty); end
        checks++; if (b_almost_full !== 1'b0) begin
            failures++; $display("FAIL reset_af_b: af=%b, need 0", b_almost_full); end
        checks++; if (a_entry_used !== 3'd0 || a_max_used !== 3'd0 || a_rd_data !== 8'h00) begin
            failures++; $display("FAIL reset_values: used=%0d max=%0d rd_data=%h, need 0/0/00",
                                 a_entry_used, a_max_used, a_rd_data); end
        checks++; if (a_wr_full_err !== 1'b0 || a_rd_empty_err !== 1'b0) begin
            failures++; $display("FAIL reset_errs: wr_err=%b rd_err=%b, need 0/0",
                                 a_wr_full_err, a_rd_empty_err); end
    endtask

    task automatic test_fill_full();
        a_drive(1, 8'h11, 8'hFF, 0, 0);
        a_drive(1, 8'h22, 8'hFF, 0, 0);
        a_drive(1, 8'h33, 8'hFF, 0, 0);
        checks++; if (a_full !== 1'b0 || a_entry_used !== 3'd3) begin
            failures++; $display("FAIL fill_3: full=%b used=%0d, need 0/3", a_full, a_entry_used); end
        a_drive(1, 8'h44, 8'hFF, 0, 0);
        checks++; if (a_full !== 1'b1 || a_entry_used !== 3'd4 || a_almost_full !== 1'b1) begin
            failures++; $display("FAIL fill_4: full=%b used=%0d af=%b, need 1/4/1",
                                 a_full, a_entry_used, a_almost_full); end
        checks++; if (a_max_used !== 3'd4) begin
            failures++; $display("FAIL fill_max: max=%0d, need 4", a_max_used); end
        a_drive(1, 8'h55, 8'hFF, 0, 0);
        checks++; if (a_wr_full_err !== 1'b1 || a_entry_used !== 3'd4) begin
            failures++; $display("FAIL overflow: wr_err=%b used=%0d, need 1/4",
                                 a_wr_full_err, a_entry_used); end
        a_drive(0, 8'h00, 8'hFF, 0, 0);
        checks++; if (a_wr_full_err !== 1'b0) begin
            failures++; $display("FAIL overflow_pulse: wr_err=%b, need 0", a_wr_full_err); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp = 8'h00;
        for (int i = 0; i < 4; i++) begin
            exp = a_sb.pop_front();
            checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== exp) begin
                failures++; $display("FAIL b2b_pop%0d: valid=%b data=%h, need 1/%h",
                                     i, a_rd_valid, a_rd_data, exp); end
            a_drive(0, 8'h00, 8'hFF, 1, 0);
        end
        checks++; if (a_empty !== 1'b1 || a_entry_used !== 3'd0 || a_rd_data !== exp) begin
            failures++; $display("FAIL drained: empty=%b used=%0d data=%h, need 1/0/%h",
                                 a_empty, a_entry_used, a_rd_data, exp); end
        a_drive(0, 8'h00, 8'hFF, 1, 0);
        checks++; if (a_rd_empty_err !== 1'b1 || a_entry_used !== 3'd0) begin
            failures++; $display("FAIL underflow: rd_err=%b used=%0d, need 1/0",
                                 a_rd_empty_err, a_entry_used); end
        a_drive(0, 8'h00, 8'hFF, 0, 0);
        checks++; if (a_rd_empty_err !== 1'b0) begin
            failures++; $display("FAIL underflow_pulse: rd_err=%b, need 0", a_rd_empty_err); end
    endtask

    task automatic test_fwft();
        logic [7:0] exp;
        a_drive(1, 8'hA5, 8'hFF, 0, 0);
        checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== a_sb[0]) begin
            failures++; $display("FAIL fwft_first: valid=%b data=%h, need 1/%h",
                                 a_rd_valid, a_rd_data, a_sb[0]); end
        a_drive(1, 8'h01, 8'hFF, 0, 0);
        a_drive(1, 8'h02, 8'hFF, 0, 0);
        a_drive(1, 8'h03, 8'hFF, 0, 0);
        exp = a_sb.pop_front();
        checks++; if (a_rd_data !== exp) begin
            failures++; $display("FAIL full_rw_head: data=%h, need %h", a_rd_data, exp); end
        a_drive(1, 8'h04, 8'hFF, 1, 0);
        checks++; if (a_entry_used !== 3'd4 || a_full !== 1'b1 || a_wr_full_err !== 1'b0) begin
            failures++; $display("FAIL full_rw: used=%0d full=%b wr_err=%b, need 4/1/0",
                                 a_entry_used, a_full, a_wr_full_err); end
        for (int i = 0; i < 4; i++) begin
            exp = a_sb.pop_front();
            checks++; if (a_rd_data !== exp) begin
                failures++; $display("FAIL full_rw_order%0d: data=%h, need %h", i, a_rd_data, exp); end
            a_drive(0, 8'h00, 8'hFF, 1, 0);
        end
    endtask

    task automatic test_mask();
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) a_drive(1, 8'hFF, 8'hFF, 0, 0);
        for (int i = 0; i < 4; i++) begin
            exp = a_sb.pop_front();
            checks++; if (a_rd_data !== exp) begin
                failures++; $display("FAIL mask_fill%0d: data=%h, need %h", i, a_rd_data, exp); end
            a_drive(0, 8'h00, 8'hFF, 1, 0);
        end
        a_drive(1, 8'h00, 8'h0F, 0, 0);
        exp = a_sb.pop_front();
        checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== exp) begin
            failures++; $display("FAIL mask_merge: valid=%b data=%h, need 1/%h",
                                 a_rd_valid, a_rd_data, exp); end
        a_drive(0, 8'h00, 8'hFF, 1, 0);
    endtask

    task automatic test_wrap_np2();
        logic [7:0] exp;
        for (int i = 0; i < 12; i++) begin
            logic rd;
            rd = (i % 3 != 0);
            if (rd && b_cnt > 0) begin
                exp = b_sb.pop_front();
                checks++; if (b_rd_data !== exp) begin
                    failures++; $display("FAIL wrap_data%0d: data=%h, need %h", i, b_rd_data, exp); end
            end
            b_drive(1, 8'(8'h30 + i), rd, 0, 0);
            checks++; if (b_entry_used !== 4'(b_cnt) || b_max_used !== 4'(b_max)) begin
                failures++; $display("FAIL wrap_count%0d: used=%0d max=%0d, need %0d/%0d",
                                     i, b_entry_used, b_max_used, b_cnt, b_max); end
        end
    endtask

    task automatic test_clr();
        logic [7:0] exp;
        exp = b_sb.pop_front();
        checks++; if (b_rd_data !== exp) begin
            failures++; $display("FAIL hwm_pop: data=%h, need %h", b_rd_data, exp); end
        b_drive(0, 8'h00, 1, 0, 1);
        checks++; if (b_entry_used !== 4'(b_cnt) || b_max_used !== 4'(b_max)) begin
            failures++; $display("FAIL hwm_clr: used=%0d max=%0d, need %0d/%0d",
                                 b_entry_used, b_max_used, b_cnt, b_max); end
        b_drive(1, 8'h99, 0, 1, 0);
        checks++; if (b_entry_used !== 4'd0 || b_empty !== 1'b1 || b_rd_valid !== 1'b0) begin
            failures++; $display("FAIL clr_state: used=%0d empty=%b valid=%b, need 0/1/0",
                                 b_entry_used, b_empty, b_rd_valid); end
        checks++; if (b_wr_full_err !== 1'b0 || b_rd_empty_err !== 1'b0 || b_max_used !== 4'(b_max)) begin
            failures++; $display("FAIL clr_side: wr_err=%b rd_err=%b max=%0d, need 0/0/%0d",
                                 b_wr_full_err, b_rd_empty_err, b_max_used, b_max); end
        b_drive(0, 8'h00, 1, 1, 0);
        checks++; if (b_rd_empty_err !== 1'b0) begin
            failures++; $display("FAIL clr_rd_empty: rd_err=%b, need 0", b_rd_empty_err); end
    endtask

    task automatic test_async_reset();
        a_drive(1, 8'h66, 8'hFF, 0, 0);
        a_drive(1, 8'h77, 8'hFF, 0, 0);
        #2;
        reset_n = 1'b0;
        a_cnt = 0; a_wp = 0; a_sb.delete();
        #1;
        checks++; if (a_entry_used !== 3'd0 || a_empty !== 1'b1 || a_rd_valid !== 1'b0) begin
            failures++; $display("FAIL areset_state: used=%0d empty=%b valid=%b, need 0/1/0",
                                 a_entry_used, a_empty, a_rd_valid); end
        checks++; if (a_rd_data !== 8'h00 || a_max_used !== 3'd0) begin
            failures++; $display("FAIL areset_data: data=%h max=%0d, need 00/0", a_rd_data, a_max_used); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        a_drive(1, 8'h5A, 8'hFF, 0, 0);
        checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== a_sb[0] || a_entry_used !== 3'd1) begin
            failures++; $display("FAIL areset_push: valid=%b data=%h used=%0d, need 1/%h/1",
                                 a_rd_valid, a_rd_data, a_entry_used, a_sb[0]); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_fill_full();
        test_back_to_back();
        test_fwft();
        test_mask();
        test_wrap_np2();
        test_clr();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
